// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: valid/ready word stream from the drain controller to its consumer.
//
// Signals:
//   m_data  - stream data (skid-buffer head)
//   m_valid - stream valid
//   m_ready - consumer ready; a word transfers when m_valid & m_ready
//
// Modports:
//   master - the producer (fifo_drain_ctrl)
//   slave  - the consumer
interface fifo_drain_ctrl_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for the 16-bit FIFO. On start it drains exactly len
// words from the FIFO (1-cycle registered read latency) into a valid/ready stream through a
// 2-entry skid buffer, sustaining one word per cycle.
//
// Ports:
//   clk       - single clock (also the FIFO read clock)
//   rst       - synchronous, active-high reset
//   start_i   - 1-cycle pulse, accepted only while idle
//   len_i     - word count, sampled when start_i is accepted
//   busy_o    - high while a transfer is in progress (RUN, FLUSH, DONE)
//   done_o    - 1-cycle pulse after the last word has been accepted downstream
//   empty_i   - FIFO empty flag
//   ren_b_o   - FIFO read enable
//   dout_b_i  - FIFO read data, valid the cycle after a read is issued
//   csum_o    - running XOR of popped words (only when DRAIN_CSUM_EN is defined)
//   m_if      - output stream (master modport)
//
// Build option: define DRAIN_CSUM_EN to add the csum_o checksum output.
module fifo_drain_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              empty_i,
  output logic              ren_b_o,
  input  logic [DATA_W-1:0] dout_b_i,
`ifdef DRAIN_CSUM_EN
  output logic [DATA_W-1:0] csum_o,
`endif
  fifo_drain_ctrl_if.master m_if
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         occ_q, occ_d;
  logic               inflight_q;
  logic [CNT_W-1:0]   rem_issue_q, rem_issue_d;
  logic [CNT_W-1:0]   rem_pop_q, rem_pop_d;
  logic [DATA_W-1:0]  buf0_q, buf0_d;
  logic [DATA_W-1:0]  buf1_q, buf1_d;

  logic               pop;
  logic               ren;
  logic               start_acc;
  logic [2:0]         outstanding;
  logic [1:0]         occ_after_pop;

  assign m_if.m_valid = (occ_q != 2'd0);
  assign m_if.m_data  = buf0_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign ren_b_o      = ren;

  assign pop       = m_if.m_valid & m_if.m_ready;
  assign start_acc = (state_q == StIdle) & start_i;

  // Words held or already requested after this cycle's pop; a new read may only be issued
  // if its data is guaranteed a free buffer slot when it arrives.
  assign outstanding = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ren = (state_q == StRun) & ~empty_i & (rem_issue_q != '0) & (outstanding < 3'd2);

  // FSM next state and transfer counters
  always_comb begin
    state_d     = state_q;
    rem_issue_d = rem_issue_q - CNT_W'(ren);
    rem_pop_d   = rem_pop_q - CNT_W'(pop);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rem_issue_d = len_i;
          rem_pop_d   = len_i;
          state_d     = (len_i != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (rem_issue_d == '0) state_d = StFlush;
      end
      StFlush: begin
        if (rem_pop_d == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: buf0 is the head; a pop shifts buf1 forward, and the captured word lands in
  // the first slot left free after the pop.
  assign occ_after_pop = occ_q - {1'b0, pop};

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_after_pop + {1'b0, inflight_q};
    if (pop) buf0_d = buf1_q;
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) buf0_d = dout_b_i;
      else                       buf1_d = dout_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      rem_issue_q <= '0;
      rem_pop_q   <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      inflight_q  <= ren;
      rem_issue_q <= rem_issue_d;
      rem_pop_q   <= rem_pop_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

`ifdef DRAIN_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // No pops occur outside a transfer, so the value naturally holds from done to next start.
  always_comb begin
    csum_d = csum_q;
    if (start_acc)  csum_d = '0;
    else if (pop)   csum_d = csum_q ^ buf0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum_o = csum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO (1-cycle registered read) and a
// negedge stream monitor. Define DRAIN_CSUM_EN to also exercise the checksum output.
module tb_fifo_drain_ctrl;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic              busy, done, empty, ren_b;
  logic [DATA_W-1:0] dout_b;
`ifdef DRAIN_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl_if #(.DATA_W(DATA_W)) m_if ();

  fifo_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .len_i    (len),
    .busy_o   (busy),
    .done_o   (done),
    .empty_i  (empty),
    .ren_b_o  (ren_b),
    .dout_b_i (dout_b),
`ifdef DRAIN_CSUM_EN
    .csum_o   (csum),
`endif
    .m_if     (m_if)
  );

  // Behavioural FIFO: read data registered one cycle after ren_b.
  logic [15:0] fifo_mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ren_b) begin
      dout_b <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  // Stream monitor, sampled mid-cycle.
  logic [15:0] pop_data [256];
  int   pop_cnt = 0, ren_cnt = 0, done_cnt = 0;
  int   over2 = 0, hold_viol = 0, ren_empty = 0, outstanding = 0;
  logic prev_stall = 1'b0, prev_rst = 1'b1;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (outstanding > 2) over2++;
    if (prev_stall && !prev_rst && !(m_if.m_valid && m_if.m_data == prev_data)) hold_viol++;
    if (ren_b && empty) ren_empty++;
    if (m_if.m_valid && m_if.m_ready) begin
      pop_data[pop_cnt[7:0]] = m_if.m_data;
      pop_cnt++;
    end
    if (ren_b) ren_cnt++;
    if (done) done_cnt++;
    if (rst) outstanding = 0;
    else outstanding = outstanding + int'(ren_b) - int'(m_if.m_valid && m_if.m_ready);
    prev_stall = m_if.m_valid && !m_if.m_ready;
    prev_data  = m_if.m_data;
    prev_rst   = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Pulses start for one cycle; returns at the first cycle after acceptance.
  task automatic start_xfer(input int unsigned n);
    start = 1'b1;
    len   = n[CNT_W-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_if.m_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset done: got %b expected 0", done); end
    tests_run++;
    if (ren_b !== 1'b0) begin tests_failed++; $display("FAIL reset ren_b: got %b expected 0", ren_b); end
    tests_run++;
    if (m_if.m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset m_valid: got %b expected 0", m_if.m_valid);
    end
    tests_run++;
    if (m_if.m_data !== 16'h0000) begin
      tests_failed++; $display("FAIL reset m_data: got %h expected 0000", m_if.m_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_rate;
    int first_ren = -1, last_ren = -1, nren = 0, first_val = -1, ndone = 0, base_pop;
    for (int i = 0; i < 10; i++) push(16'h1000 + 16'(i));
    m_if.m_ready = 1'b1;
    base_pop = pop_cnt;
    start_xfer(10);
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (ren_b) begin
        if (first_ren < 0) first_ren = c;
        last_ren = c;
        nren++;
      end
      if (m_if.m_valid && first_val < 0) first_val = c;
      if (done) ndone++;
      tick();
    end
    tests_run++;
    if (first_ren != 1) begin
      tests_failed++; $display("FAIL full_rate first_ren: got %0d expected 1", first_ren);
    end
    tests_run++;
    if (nren != 10 || last_ren != 10) begin
      tests_failed++; $display("FAIL full_rate ren run: got %0d ending %0d expected 10 ending 10",
                               nren, last_ren);
    end
    tests_run++;
    if (first_val != 3) begin
      tests_failed++; $display("FAIL full_rate first_valid: got %0d expected 3", first_val);
    end
    tests_run++;
    if (pop_cnt - base_pop != 10) begin
      tests_failed++; $display("FAIL full_rate pops: got %0d expected 10", pop_cnt - base_pop);
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (pop_data[8'(base_pop + i)] !== 16'h1000 + 16'(i)) begin
        tests_failed++;
        $display("FAIL full_rate word%0d: got %h expected %h", i, pop_data[8'(base_pop + i)],
                 16'h1000 + 16'(i));
      end
    end
    tests_run++;
    if (ndone != 1) begin tests_failed++; $display("FAIL full_rate done: got %0d expected 1", ndone); end
    tests_run++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL full_rate end: got empty=%b busy=%b expected 1 0", empty, busy);
    end
  endtask

  task automatic test_backpressure;
    int base_pop = pop_cnt, base_ren = ren_cnt, base_over = over2, base_hold = hold_viol;
    int base_done = done_cnt, c = 1;
    bit found = 1'b0;
    for (int i = 0; i < 6; i++) push(16'h2000 + 16'(i));
    m_if.m_ready = 1'b1;
    start_xfer(6);
    while (!found && c < 80) begin
      m_if.m_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (done) found = 1'b1;
      tick();
      c++;
    end
    m_if.m_ready = 1'b1;
    tick();
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL backpressure done: got timeout expected done"); end
    tests_run++;
    if (pop_cnt - base_pop != 6) begin
      tests_failed++; $display("FAIL backpressure pops: got %0d expected 6", pop_cnt - base_pop);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (pop_data[8'(base_pop + i)] !== 16'h2000 + 16'(i)) begin
        tests_failed++;
        $display("FAIL backpressure word%0d: got %h expected %h", i, pop_data[8'(base_pop + i)],
                 16'h2000 + 16'(i));
      end
    end
    tests_run++;
    if (ren_cnt - base_ren != 6) begin
      tests_failed++; $display("FAIL backpressure reads: got %0d expected 6", ren_cnt - base_ren);
    end
    tests_run++;
    if (over2 != base_over) begin
      tests_failed++; $display("FAIL backpressure outstanding>2: got %0d cycles expected 0",
                               over2 - base_over);
    end
    tests_run++;
    if (hold_viol != base_hold) begin
      tests_failed++; $display("FAIL backpressure hold: got %0d violations expected 0",
                               hold_viol - base_hold);
    end
    tests_run++;
    if (done_cnt - base_done != 1) begin
      tests_failed++; $display("FAIL backpressure done count: got %0d expected 1",
                               done_cnt - base_done);
    end
  endtask

  task automatic test_empty_stall;
    int base_pop = pop_cnt, base_ren = ren_cnt, base_re = ren_empty, base_done = done_cnt;
    bit found;
    push(16'h3000);
    push(16'h3001);
    m_if.m_ready = 1'b1;
    start_xfer(4);
    repeat (20) tick();
    tests_run++;
    if (pop_cnt - base_pop != 2 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL empty_stall mid: got pops=%0d busy=%b expected 2 1",
                               pop_cnt - base_pop, busy);
    end
    tests_run++;
    if (ren_cnt - base_ren != 2 || done_cnt != base_done) begin
      tests_failed++; $display("FAIL empty_stall stalled: got reads=%0d dones=%0d expected 2 0",
                               ren_cnt - base_ren, done_cnt - base_done);
    end
    push(16'h3002);
    push(16'h3003);
    wait_done(20, found);
    tick();
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL empty_stall done: got timeout expected done"); end
    tests_run++;
    if (ren_empty != base_re) begin
      tests_failed++; $display("FAIL empty_stall ren_while_empty: got %0d expected 0",
                               ren_empty - base_re);
    end
    tests_run++;
    if (pop_cnt - base_pop != 4) begin
      tests_failed++; $display("FAIL empty_stall pops: got %0d expected 4", pop_cnt - base_pop);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (pop_data[8'(base_pop + i)] !== 16'h3000 + 16'(i)) begin
        tests_failed++;
        $display("FAIL empty_stall word%0d: got %h expected %h", i, pop_data[8'(base_pop + i)],
                 16'h3000 + 16'(i));
      end
    end
  endtask

  task automatic test_len0_and_busy_start;
    int base_ren = ren_cnt, base_pop, dc = -1, ndone = 0;
    bit found;
    m_if.m_ready = 1'b1;
    start_xfer(0);
    for (int c = 1; c <= 4; c++) begin
      if (done) begin
        if (dc < 0) dc = c;
        ndone++;
      end
      tick();
    end
    tests_run++;
    if (!(dc >= 1 && dc <= 2) || ndone != 1) begin
      tests_failed++; $display("FAIL len0 done: got at %0d count %0d expected at 1..2 count 1",
                               dc, ndone);
    end
    tests_run++;
    if (ren_cnt != base_ren || busy !== 1'b0) begin
      tests_failed++; $display("FAIL len0 reads: got %0d busy=%b expected 0 0",
                               ren_cnt - base_ren, busy);
    end
    // Stall a 3-word transfer in RUN, then try to restart it.
    for (int i = 0; i < 3; i++) push(16'h4000 + 16'(i));
    base_ren = ren_cnt;
    base_pop = pop_cnt;
    m_if.m_ready = 1'b0;
    start_xfer(3);
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b1 || ren_b !== 1'b0) begin
      tests_failed++; $display("FAIL busy_start throttle: got busy=%b ren_b=%b expected 1 0",
                               busy, ren_b);
    end
    start = 1'b1;
    len = CNT_W'(7);
    tick();
    start = 1'b0;
    m_if.m_ready = 1'b1;
    wait_done(20, found);
    tick();
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL busy_start done: got timeout expected done"); end
    tests_run++;
    if (ren_cnt - base_ren != 3 || pop_cnt - base_pop != 3) begin
      tests_failed++; $display("FAIL busy_start counts: got reads=%0d pops=%0d expected 3 3",
                               ren_cnt - base_ren, pop_cnt - base_pop);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pop_data[8'(base_pop + i)] !== 16'h4000 + 16'(i)) begin
        tests_failed++;
        $display("FAIL busy_start word%0d: got %h expected %h", i, pop_data[8'(base_pop + i)],
                 16'h4000 + 16'(i));
      end
    end
  endtask

`ifdef DRAIN_CSUM_EN
  task automatic test_csum;
    bit found;
    push(16'h00FF);
    push(16'h0F0F);
    push(16'hFFFF);
    m_if.m_ready = 1'b1;
    start_xfer(3);
    wait_done(15, found);
    tests_run++;
    if (!found || csum !== 16'hF00F) begin
      tests_failed++; $display("FAIL csum at_done: got %h found=%b expected f00f", csum, found);
    end
    repeat (3) tick();
    tests_run++;
    if (csum !== 16'hF00F) begin
      tests_failed++; $display("FAIL csum hold: got %h expected f00f", csum);
    end
    start_xfer(0);
    tests_run++;
    if (csum !== 16'h0000) begin
      tests_failed++; $display("FAIL csum clear: got %h expected 0000", csum);
    end
    repeat (3) tick();
  endtask
`endif

  // Reset lands in the cycle of the 3rd pop. By then words 1..5 have left the FIFO
  // (4 captured, 5 in flight), so both are discarded and a restart sees 6, 7, 8.
  task automatic test_reset_mid;
    int base_pop = pop_cnt;
    for (int i = 1; i <= 8; i++) push(16'(i));
    m_if.m_ready = 1'b1;
    start_xfer(8);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || m_if.m_valid !== 1'b0 || ren_b !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid outputs: got busy=%b m_valid=%b ren_b=%b expected 0 0 0",
                               busy, m_if.m_valid, ren_b);
    end
    tests_run++;
    if (pop_cnt - base_pop != 3) begin
      tests_failed++; $display("FAIL reset_mid pops_before: got %0d expected 3", pop_cnt - base_pop);
    end
    tick();
    start_xfer(5);
    repeat (15) tick();
    tests_run++;
    if (pop_cnt - base_pop != 6) begin
      tests_failed++; $display("FAIL reset_mid pops_total: got %0d expected 6", pop_cnt - base_pop);
    end
    for (int i = 0; i < 6; i++) begin
      logic [15:0] exp_w;
      exp_w = (i < 3) ? 16'(i + 1) : 16'(i + 3);
      tests_run++;
      if (pop_data[8'(base_pop + i)] !== exp_w) begin
        tests_failed++;
        $display("FAIL reset_mid word%0d: got %h expected %h", i, pop_data[8'(base_pop + i)], exp_w);
      end
    end
    tests_run++;
    if (busy !== 1'b1 || ren_b !== 1'b0 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid waiting: got busy=%b ren_b=%b empty=%b expected 1 0 1",
                               busy, ren_b, empty);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_empty_stall();
    test_len0_and_busy_start();
`ifdef DRAIN_CSUM_EN
    test_csum();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
